header_ram_ctrl: RTL and testbench
==================================

# header_ram_ctrl

Sequencer for the dual-port header RAM. The RAM is 2^RAM_ADRB words of RAM_WIDTH bits, with port A write-only, port B read-only and a registered 1-cycle read. This block runs it as a circular buffer of variable-length header frames. The event builder writes frames word by word; the readout engine requests whole frames and gets them back in arrival order. Frames that do not fit are dropped whole, and the drop is flagged.

## Interface
Parameters
- RAM_WIDTH, 9, header word width; matches the RAM.
- RAM_ADRB, 11, RAM address bits; the buffer holds 2^RAM_ADRB words.
- LEN_ADRB, 3, address bits of the frame-length FIFO; at most 2^LEN_ADRB committed frames can be held.

Ports
- clock  in  1  single clock for the block and the RAM.
- reset  in  1  asynchronous, active-high.
- wr_valid  in  1  header word present.
- wr_data  in  RAM_WIDTH  header word.
- wr_last  in  1  this word ends the frame; qualified by wr_valid.
- rd_start  in  1  request readout of the oldest committed frame.
- rd_busy  out  1  readout in progress.
- out_valid  out  1  out_data holds a frame word.
- out_data  out  RAM_WIDTH  frame word, taken from ram_datab.
- out_last  out  1  last word of the frame; qualified by out_valid.
- nframes  out  LEN_ADRB+1  number of committed, unread frames.
- nwords  out  RAM_ADRB+1  words occupied, including the uncommitted frame in progress.
- ovf  out  1  one-cycle pulse when a frame is dropped.
- ovf_cnt  out  8  count of dropped frames; saturates at 255.
- ram_wea  out  1  to RAM port A write enable.
- ram_adra  out  RAM_ADRB  to RAM port A address.
- ram_dataa  out  RAM_WIDTH  to RAM port A data.
- ram_enb  out  1  to RAM port B enable.
- ram_adrb  out  RAM_ADRB  to RAM port B address.
- ram_datab  in  RAM_WIDTH  from RAM port B data.

## Operation
Pointers and lengths
- Pointers: wr_ptr (next write), cmt_ptr (start of the uncommitted frame), rd_ptr (next read). All are RAM_ADRB wide and wrap modulo 2^RAM_ADRB.
- Length FIFO: 2^LEN_ADRB entries of RAM_ADRB+1 bits, one per committed frame.

Write FSM
- W_IDLE:
  - The first wr_valid starts a frame and clears len_acc.
  - If there is space, go to W_FILL; otherwise go to W_DROP.
  - "Space" means nwords < 2^RAM_ADRB and the length FIFO is not full.
- W_FILL, on each accepted word:
  - ram_wea=1, ram_adra=wr_ptr, ram_dataa=wr_data.
  - wr_ptr+1 and len_acc+1.
- W_FILL, on wr_last:
  - Push len_acc+1 into the length FIFO.
  - cmt_ptr becomes wr_ptr+1.
  - Return to W_IDLE.
- W_FILL, when a word arrives with nwords = 2^RAM_ADRB:
  - Do not write the word.
  - Go to W_DROP.
- W_DROP:
  - Discard words up to and including wr_last.
  - On wr_last: wr_ptr is rewound to cmt_ptr, nwords is restored, ovf is pulsed, ovf_cnt+1, and the FSM returns to W_IDLE.
  - A single-word frame (wr_last on its first word) that finds no space is dropped the same way.

Read FSM
- R_IDLE:
  - rd_start with nframes > 0: pop the length into rd_rem and go to R_READ.
  - rd_start with nframes = 0 is ignored.
  - rd_start while rd_busy is ignored.
- R_READ, each cycle:
  - ram_enb=1, ram_adrb=rd_ptr.
  - rd_ptr+1, rd_rem-1, nwords-1.
  - When rd_rem reaches 1 at issue, go to R_DRAIN.
- R_DRAIN: one cycle for the last RAM read to come back, then go to R_IDLE.
- ram_enb=0 whenever no read is being issued, so port B is idle.
- A committed frame has at least 1 word; lengths of 0 cannot occur.

Counters
- nframes: +1 on commit, −1 on pop. Commit and pop in the same cycle leave it unchanged.
- nwords: +1 per write, −1 per read issue. A write and a read issue in the same cycle leave it unchanged.

Collision-free by construction
- Reads touch only committed words.
- The full check stops wr_ptr from wrapping onto unread data.

## Timing
- Reset values:
  - All pointers, counters and nframes 0; ovf_cnt 0.
  - Both FSMs idle.
  - All outputs 0.
- Write: accepted at the wr_valid edge. The frame is visible in nframes the cycle after its wr_last.
- Read:
  - rd_start at edge N → first ram_enb at edge N+1.
  - out_valid/out_data follow each ram_enb by 1 cycle.
  - A frame of L words gives out_valid for L consecutive cycles, starting at N+2; out_last is on the final one.
- rd_busy: high from N+1 through the cycle of out_last.
- Back-to-back readout: the next rd_start is accepted at the earliest on the cycle out_last is high. There are no gaps within a frame.
- Reset mid-frame: the partial frame is lost, and all state clears asynchronously.

## Test plan
- Single frame: write 5 words 0x101..0x105, wr_last on 0x105; rd_start → out_data 0x101..0x105 on 5 consecutive cycles starting 2 cycles after rd_start; out_last with 0x105; nframes 1→0; nwords 5→0.
- Wrap: with RAM_ADRB=4, write and read 3 frames of 7 words each, in sequence → all data exact across the address wrap; no ovf.
- Buffer overflow: with RAM_ADRB=4 and no reads, write frame A of 12 words, then frame B of 6 words → B dropped; ovf pulses once; ovf_cnt=1; nwords=12; a read returns only A.
- Length FIFO full: write 9 one-word frames with LEN_ADRB=3 → the 9th is dropped; nframes=8; ovf_cnt=1.
- Concurrent write/read: stream frame 2 in while frame 1 is read out → both frames intact; nwords is consistent every cycle; ram_enb is low outside reads.
- Reset mid-read: assert reset during the 3rd output word → all outputs 0 immediately; the next rd_start is ignored (nframes=0).

Source files
------------

// File: rtl/header_ram_ctrl.sv
// Header RAM sequencer: keeps variable-length header frames in a circular buffer,
// drops frames that do not fit as a whole, and reads committed frames back in arrival order.
module header_ram_ctrl #(
    parameter int RAM_WIDTH = 9,
    parameter int RAM_ADRB  = 11,
    parameter int LEN_ADRB  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_valid,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 wr_last,
    input  logic                 rd_start,
    output logic                 rd_busy,
    output logic                 out_valid,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [LEN_ADRB:0]    nframes,
    output logic [RAM_ADRB:0]    nwords,
    output logic                 ovf,
    output logic [7:0]           ovf_cnt,
    output logic                 ram_wea,
    output logic [RAM_ADRB-1:0]  ram_adra,
    output logic [RAM_WIDTH-1:0] ram_dataa,
    output logic                 ram_enb,
    output logic [RAM_ADRB-1:0]  ram_adrb,
    input  logic [RAM_WIDTH-1:0] ram_datab
);

    localparam int                LEN_DEPTH   = 2 ** LEN_ADRB;
    localparam logic [RAM_ADRB:0] FULL_WORDS  = {1'b1, {RAM_ADRB{1'b0}}};
    localparam logic [LEN_ADRB:0] FULL_FRAMES = {1'b1, {LEN_ADRB{1'b0}}};
    localparam logic [RAM_ADRB:0] ONE_W       = {{RAM_ADRB{1'b0}}, 1'b1};
    localparam logic [RAM_ADRB:0] ZERO_W      = {(RAM_ADRB+1){1'b0}};
    localparam logic [LEN_ADRB:0] ONE_F       = {{LEN_ADRB{1'b0}}, 1'b1};
    localparam logic [LEN_ADRB:0] ZERO_F      = {(LEN_ADRB+1){1'b0}};

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_FILL = 2'd1, W_DROP = 2'd2} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_READ = 2'd1, R_DRAIN = 2'd2} rstate_t;

    wstate_t               wstate_r, wstate_s;
    rstate_t               rstate_r, rstate_s;
    logic [RAM_ADRB-1:0]   wr_ptr_r, cmt_ptr_r, rd_ptr_r;
    logic [RAM_ADRB:0]     len_acc_r, rd_rem_r, nwords_r, nwords_s, len_base_s;
    logic [LEN_ADRB:0]     nframes_r, nframes_s;
    logic [RAM_ADRB:0]     len_mem_r [LEN_DEPTH];
    logic [LEN_ADRB-1:0]   lf_wptr_r, lf_rptr_r;
    logic                  ovf_r;
    logic [7:0]            ovf_cnt_r;
    logic                  words_full_s, frames_full_s, space_s;
    logic                  accept_s, commit_s, drop_end_s, pop_s, issue_s;
    logic                  ram_wea_r, ram_enb_r, enb_last_r;
    logic [RAM_ADRB-1:0]   ram_adra_r, ram_adrb_r;
    logic [RAM_WIDTH-1:0]  ram_dataa_r;
    logic                  out_valid_r, out_last_r, rd_busy_r;

    assign words_full_s  = (nwords_r == FULL_WORDS);
    assign frames_full_s = (nframes_r == FULL_FRAMES);

    // Write FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wstate_r <= W_IDLE;
        end else begin
            wstate_r <= wstate_s;
        end
    end

    // Write FSM next state
    always_comb begin
        wstate_s = wstate_r;
        case (wstate_r)
            W_IDLE: begin
                if (wr_valid && !wr_last) begin
                    wstate_s = space_s ? W_FILL : W_DROP;
                end else begin
                    wstate_s = W_IDLE;
                end
            end
            W_FILL: begin
                if (wr_valid && wr_last) begin
                    wstate_s = W_IDLE;
                end else if (wr_valid && !space_s) begin
                    wstate_s = W_DROP;
                end else begin
                    wstate_s = W_FILL;
                end
            end
            W_DROP: begin
                if (wr_valid && wr_last) begin
                    wstate_s = W_IDLE;
                end else begin
                    wstate_s = W_DROP;
                end
            end
            default: wstate_s = W_IDLE;
        endcase
    end

    // Write FSM outputs: the first word of a frame is stored from W_IDLE already
    always_comb begin
        space_s = 1'b0;
        case (wstate_r)
            W_IDLE:  space_s = !words_full_s && !frames_full_s;
            W_FILL:  space_s = !words_full_s;
            W_DROP:  space_s = 1'b0;
            default: space_s = 1'b0;
        endcase
        accept_s   = wr_valid && space_s;
        commit_s   = accept_s && wr_last;
        drop_end_s = wr_valid && wr_last && !space_s;
        len_base_s = (wstate_r == W_IDLE) ? ZERO_W : len_acc_r;
    end

    // Write pointers, frame length accumulator and length FIFO write side
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= '0;
            cmt_ptr_r <= '0;
            len_acc_r <= '0;
            lf_wptr_r <= '0;
        end else begin
            if (drop_end_s) begin
                wr_ptr_r <= cmt_ptr_r;
            end else if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (commit_s) begin
                cmt_ptr_r <= wr_ptr_r + 1'b1;
                lf_wptr_r <= lf_wptr_r + 1'b1;
            end
            if (accept_s) begin
                len_acc_r <= len_base_s + ONE_W;
            end else if (wstate_r == W_IDLE) begin
                len_acc_r <= ZERO_W;
            end
        end
    end

    // Length FIFO storage, one entry per committed frame
    always_ff @(posedge clock) begin
        if (commit_s) begin
            len_mem_r[lf_wptr_r] <= len_base_s + ONE_W;
        end
    end

    // Read FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rstate_r <= R_IDLE;
        end else begin
            rstate_r <= rstate_s;
        end
    end

    // Read FSM next state
    always_comb begin
        rstate_s = rstate_r;
        case (rstate_r)
            R_IDLE:  rstate_s = pop_s ? R_READ : R_IDLE;
            R_READ:  rstate_s = (rd_rem_r == ONE_W) ? R_DRAIN : R_READ;
            R_DRAIN: rstate_s = R_IDLE;
            default: rstate_s = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        pop_s   = (rstate_r == R_IDLE) && rd_start && (nframes_r != ZERO_F);
        issue_s = (rstate_r == R_READ);
    end

    // Read pointer, remaining length and length FIFO read side
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_r  <= '0;
            rd_rem_r  <= '0;
            lf_rptr_r <= '0;
        end else begin
            if (pop_s) begin
                rd_rem_r  <= len_mem_r[lf_rptr_r];
                lf_rptr_r <= lf_rptr_r + 1'b1;
            end else if (issue_s) begin
                rd_rem_r <= rd_rem_r - ONE_W;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Occupancy: a dropped frame gives back every word it had already stored
    always_comb begin
        nwords_s  = nwords_r + (accept_s ? ONE_W : ZERO_W) - (issue_s ? ONE_W : ZERO_W)
                  - (drop_end_s ? len_base_s : ZERO_W);
        nframes_s = nframes_r + (commit_s ? ONE_F : ZERO_F) - (pop_s ? ONE_F : ZERO_F);
    end

    // Counters and overflow reporting
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nwords_r  <= '0;
            nframes_r <= '0;
            ovf_r     <= 1'b0;
            ovf_cnt_r <= 8'd0;
        end else begin
            nwords_r  <= nwords_s;
            nframes_r <= nframes_s;
            ovf_r     <= drop_end_s;
            if (drop_end_s && (ovf_cnt_r != 8'd255)) begin
                ovf_cnt_r <= ovf_cnt_r + 8'd1;
            end
        end
    end

    // Registered RAM port drive and output framing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_wea_r   <= 1'b0;
            ram_adra_r  <= '0;
            ram_dataa_r <= '0;
            ram_enb_r   <= 1'b0;
            ram_adrb_r  <= '0;
            enb_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            rd_busy_r   <= 1'b0;
        end else begin
            ram_wea_r   <= accept_s;
            ram_adra_r  <= accept_s ? wr_ptr_r : '0;
            ram_dataa_r <= accept_s ? wr_data : '0;
            ram_enb_r   <= issue_s;
            ram_adrb_r  <= issue_s ? rd_ptr_r : '0;
            enb_last_r  <= issue_s && (rd_rem_r == ONE_W);
            out_valid_r <= ram_enb_r;
            out_last_r  <= enb_last_r;
            rd_busy_r   <= issue_s || ram_enb_r;
        end
    end

    assign ram_wea   = ram_wea_r;
    assign ram_adra  = ram_adra_r;
    assign ram_dataa = ram_dataa_r;
    assign ram_enb   = ram_enb_r;
    assign ram_adrb  = ram_adrb_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    // The RAM output register is the data stage; gate it so idle and reset show zero
    assign out_data  = out_valid_r ? ram_datab : '0;
    assign rd_busy   = rd_busy_r;
    assign nframes   = nframes_r;
    assign nwords    = nwords_r;
    assign ovf       = ovf_r;
    assign ovf_cnt   = ovf_cnt_r;

endmodule

// File: tb/tb_header_ram_ctrl.sv
// Self-checking bench for header_ram_ctrl: a frame-level reference model (queues of
// committed frames, occupancy and drop count) checked against randomized traffic.
module tb_header_ram_ctrl;

    localparam int W    = 9;
    localparam int AB   = 4;
    localparam int LB   = 3;
    localparam int CAP  = 16;
    localparam int FCAP = 8;

    logic          clock, reset, wr_valid, wr_last, rd_start;
    logic [W-1:0]  wr_data;
    logic          rd_busy, out_valid, out_last, ovf, ram_wea, ram_enb;
    logic [W-1:0]  out_data, ram_dataa, ram_datab;
    logic [LB:0]   nframes;
    logic [AB:0]   nwords;
    logic [7:0]    ovf_cnt;
    logic [AB-1:0] ram_adra, ram_adrb;
    logic [W-1:0]  mem [CAP];

    int n_checks = 0;
    int n_fail   = 0;
    int mocc     = 0;
    int mfr      = 0;
    int movf     = 0;
    logic [W-1:0] mdata [$];
    int           mlen  [$];
    logic [W-1:0] wbuf  [$];

    header_ram_ctrl #(.RAM_WIDTH(W), .RAM_ADRB(AB), .LEN_ADRB(LB)) dut (
        .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_last(wr_last), .rd_start(rd_start), .rd_busy(rd_busy), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .nframes(nframes), .nwords(nwords),
        .ovf(ovf), .ovf_cnt(ovf_cnt), .ram_wea(ram_wea), .ram_adra(ram_adra),
        .ram_dataa(ram_dataa), .ram_enb(ram_enb), .ram_adrb(ram_adrb), .ram_datab(ram_datab)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Dual-port RAM with registered read
    always @(posedge clock) begin
        if (ram_wea) mem[ram_adra] <= ram_dataa;
        if (ram_enb) ram_datab <= mem[ram_adrb];
    end

    task automatic fill_random(input int len);
        wbuf.delete();
        for (int i = 0; i < len; i++) wbuf.push_back(W'($urandom_range(0, 511)));
    endtask

    task automatic write_frame();
        int  len;
        int  pulses;
        bit  dropped;
        len     = wbuf.size();
        dropped = (mfr == FCAP) || (mocc + len > CAP);
        pulses  = 0;
        for (int i = 0; i < len; i++) begin
            wr_valid = 1'b1; wr_data = wbuf[i]; wr_last = (i == len - 1);
            @(negedge clock);
            if (ovf === 1'b1) pulses++;
        end
        wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
        @(negedge clock);
        if (ovf === 1'b1) pulses++;
        if (dropped) begin
            movf = (movf < 255) ? movf + 1 : 255;
        end else begin
            foreach (wbuf[i]) mdata.push_back(wbuf[i]);
            mlen.push_back(len);
            mocc += len;
            mfr++;
        end
        n_checks++;
        if (pulses != (dropped ? 1 : 0)) begin
            n_fail++; $display("FAIL wr_ovf_pulses: got %0d expected %0d", pulses, dropped ? 1 : 0);
        end
        n_checks++;
        if (nframes !== (LB+1)'(mfr)) begin
            n_fail++; $display("FAIL wr_nframes: got %0d expected %0d", nframes, mfr);
        end
        n_checks++;
        if (nwords !== (AB+1)'(mocc)) begin
            n_fail++; $display("FAIL wr_nwords: got %0d expected %0d", nwords, mocc);
        end
        n_checks++;
        if (ovf_cnt !== 8'(movf)) begin
            n_fail++; $display("FAIL wr_ovf_cnt: got %0d expected %0d", ovf_cnt, movf);
        end
    endtask

    task automatic read_frame();
        int           len;
        bit           has;
        logic [W-1:0] exp_d;
        has = (mlen.size() > 0);
        len = has ? mlen.pop_front() : 0;
        if (has) mfr--;
        rd_start = 1'b1;
        @(negedge clock);
        rd_start = 1'b0;
        n_checks++;
        if (nframes !== (LB+1)'(mfr)) begin
            n_fail++; $display("FAIL rd_nframes: got %0d expected %0d", nframes, mfr);
        end
        @(negedge clock);
        n_checks++;
        if ({rd_busy, out_valid} !== {has, 1'b0}) begin
            n_fail++; $display("FAIL rd_busy_start: got %b expected %b", {rd_busy, out_valid}, {has, 1'b0});
        end
        if (has) begin
            for (int i = 0; i < len; i++) begin
                @(negedge clock);
                exp_d = mdata.pop_front();
                n_checks++;
                if ({out_valid, out_last, out_data} !== {1'b1, (i == len - 1), exp_d}) begin
                    n_fail++;
                    $display("FAIL rd_word[%0d]: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                             i, out_valid, out_last, out_data, (i == len - 1), exp_d);
                end
            end
        end else begin
            repeat (3) begin
                @(negedge clock);
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rd_empty_ignored: got out_valid=%b expected 0", out_valid);
                end
            end
        end
        @(negedge clock);
        mocc -= len;
        n_checks++;
        if ({out_valid, rd_busy} !== 2'b00) begin
            n_fail++; $display("FAIL rd_end_idle: got %b expected 00", {out_valid, rd_busy});
        end
        n_checks++;
        if (nwords !== (AB+1)'(mocc)) begin
            n_fail++; $display("FAIL rd_nwords: got %0d expected %0d", nwords, mocc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({rd_busy, out_valid, out_last, ovf, ram_wea, ram_enb} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                               {rd_busy, out_valid, out_last, ovf, ram_wea, ram_enb});
        end
        n_checks++;
        if ({nframes, nwords, ovf_cnt} !== 17'd0) begin
            n_fail++; $display("FAIL reset_counts: got nf=%0d nw=%0d oc=%0d expected 0", nframes, nwords, ovf_cnt);
        end
        n_checks++;
        if ({out_data, ram_adra, ram_dataa, ram_adrb} !== 26'd0) begin
            n_fail++; $display("FAIL reset_buses: got %h expected 0", {out_data, ram_adra, ram_dataa, ram_adrb});
        end
    endtask

    task automatic test_single_frame();
        wbuf.delete();
        for (int i = 0; i < 5; i++) wbuf.push_back(W'(9'h101 + i));
        write_frame();
        read_frame();
    endtask

    task automatic test_wrap();
        for (int f = 0; f < 3; f++) begin
            fill_random(7);
            write_frame();
            read_frame();
        end
    endtask

    task automatic test_overflow();
        fill_random(12);
        write_frame();
        fill_random(6);
        write_frame();
        read_frame();
        read_frame();
    endtask

    task automatic test_len_fifo_full();
        for (int f = 0; f < FCAP + 1; f++) begin
            fill_random(1);
            write_frame();
        end
        while (mlen.size() > 0) read_frame();
    endtask

    task automatic test_concurrent();
        logic [W-1:0] f1 [$];
        logic [W-1:0] f2 [$];
        int l1, l2, iss, wrn, exp_nw;
        bit ov;
        l1 = $urandom_range(3, 6);
        l2 = $urandom_range(3, 6);
        fill_random(l1);
        f1 = wbuf;
        write_frame();
        mdata.delete(); mlen.delete(); mfr = 0; mocc = 0;
        fill_random(l2);
        f2 = wbuf;
        for (int t = 0; t < l1 + l2 + 4; t++) begin
            rd_start = (t == 0);
            wr_valid = (t >= 1) && (t <= l2);
            wr_data  = wr_valid ? f2[t-1] : '0;
            wr_last  = (t == l2);
            @(negedge clock);
            iss    = (t < l1) ? t : l1;
            wrn    = (t < l2) ? t : l2;
            exp_nw = l1 + wrn - iss;
            n_checks++;
            if (nwords !== (AB+1)'(exp_nw)) begin
                n_fail++; $display("FAIL cc_nwords t=%0d: got %0d expected %0d", t, nwords, exp_nw);
            end
            n_checks++;
            if (ram_enb !== ((t >= 1) && (t <= l1))) begin
                n_fail++; $display("FAIL cc_ram_enb t=%0d: got %b expected %b", t, ram_enb, (t >= 1) && (t <= l1));
            end
            ov = (t >= 2) && (t <= l1 + 1);
            n_checks++;
            if (ov) begin
                if ({out_valid, out_last, out_data} !== {1'b1, (t == l1 + 1), f1[t-2]}) begin
                    n_fail++; $display("FAIL cc_out t=%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                                       t, out_valid, out_last, out_data, (t == l1 + 1), f1[t-2]);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL cc_out_idle t=%0d: got out_valid=%b expected 0", t, out_valid);
            end
            n_checks++;
            if (nframes !== ((t >= l2) ? 4'd1 : 4'd0)) begin
                n_fail++; $display("FAIL cc_nframes t=%0d: got %0d expected %0d", t, nframes, (t >= l2) ? 1 : 0);
            end
        end
        rd_start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
        foreach (f2[i]) mdata.push_back(f2[i]);
        mlen.push_back(l2);
        mfr  = 1;
        mocc = l2;
        read_frame();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] f1 [$];
        logic [W-1:0] f2 [$];
        int l1, l2, s2;
        bit ov1, ov2, exp_busy;
        l1 = $urandom_range(3, 6);
        l2 = $urandom_range(1, 6);
        fill_random(l1); f1 = wbuf; write_frame();
        fill_random(l2); f2 = wbuf; write_frame();
        mdata.delete(); mlen.delete(); mfr = 0; mocc = 0;
        s2 = l1 + 2;
        for (int t = 0; t < s2 + l2 + 4; t++) begin
            rd_start = (t == 0) || (t == 3) || (t == s2);
            @(negedge clock);
            ov1 = (t >= 2) && (t <= l1 + 1);
            ov2 = (t >= s2 + 2) && (t <= s2 + l2 + 1);
            n_checks++;
            if (ov1) begin
                if ({out_valid, out_last, out_data} !== {1'b1, (t == l1 + 1), f1[t-2]}) begin
                    n_fail++; $display("FAIL b2b_f1 t=%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                                       t, out_valid, out_last, out_data, (t == l1 + 1), f1[t-2]);
                end
            end else if (ov2) begin
                if ({out_valid, out_last, out_data} !== {1'b1, (t == s2 + l2 + 1), f2[t-s2-2]}) begin
                    n_fail++; $display("FAIL b2b_f2 t=%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                                       t, out_valid, out_last, out_data, (t == s2 + l2 + 1), f2[t-s2-2]);
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL b2b_gap t=%0d: got out_valid=%b expected 0", t, out_valid);
            end
            exp_busy = ((t >= 1) && (t <= l1 + 1)) || ((t >= s2 + 1) && (t <= s2 + l2 + 1));
            n_checks++;
            if (rd_busy !== exp_busy) begin
                n_fail++; $display("FAIL b2b_busy t=%0d: got %b expected %b", t, rd_busy, exp_busy);
            end
            n_checks++;
            if (nframes !== ((t >= s2) ? 4'd0 : 4'd1)) begin
                n_fail++; $display("FAIL b2b_nframes t=%0d: got %0d expected %0d", t, nframes, (t >= s2) ? 0 : 1);
            end
        end
        rd_start = 1'b0;
        n_checks++;
        if (nwords !== 5'd0) begin
            n_fail++; $display("FAIL b2b_nwords: got %0d expected 0", nwords);
        end
    endtask

    task automatic test_random();
        int nf, nr;
        for (int r = 0; r < 12; r++) begin
            nf = $urandom_range(1, 4);
            for (int f = 0; f < nf; f++) begin
                fill_random($urandom_range(1, 9));
                write_frame();
            end
            nr = $urandom_range(0, mlen.size());
            for (int k = 0; k < nr; k++) read_frame();
        end
        while (mlen.size() > 0) read_frame();
        read_frame();
    endtask

    task automatic test_reset_mid_read();
        fill_random(6);
        write_frame();
        rd_start = 1'b1;
        @(negedge clock);
        rd_start = 1'b0;
        repeat (4) @(negedge clock);
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, wbuf[2]}) begin
            n_fail++; $display("FAIL rst_third_word: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, wbuf[2]);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_last, rd_busy, ram_enb, ram_wea, ovf} !== 6'b0) begin
            n_fail++; $display("FAIL rst_async_flags: got %b expected 000000",
                               {out_valid, out_last, rd_busy, ram_enb, ram_wea, ovf});
        end
        n_checks++;
        if ({out_data, nframes, nwords, ovf_cnt} !== 26'd0) begin
            n_fail++; $display("FAIL rst_async_state: got d=%h nf=%0d nw=%0d oc=%0d expected 0",
                               out_data, nframes, nwords, ovf_cnt);
        end
        @(negedge clock);
        reset = 1'b0;
        mdata.delete(); mlen.delete(); mfr = 0; mocc = 0; movf = 0;
        read_frame();
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0; rd_start = 1'b0;
        test_reset();
        test_single_frame();
        test_wrap();
        test_overflow();
        test_len_fifo_full();
        test_concurrent();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
